// File: rtl/cpu_prefetch.sv
// Instruction prefetcher: fetches sequential words over a single-outstanding
// read bus into a small {instruction, pc} queue, with flush/redirect support.
module cpu_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_request,
  output logic        o_rw,
  output logic [31:0] o_address,
  input  logic        i_ready,
  input  logic [31:0] i_data,
  output logic        o_valid,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  input  logic        i_pop,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc,
  output logic [1:0]  o_dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_ISSUE   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_request;
  logic [31:0]     r_address;
  logic [31:0]     r_fetch_pc;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [31:0]     r_mem_instr [DEPTH];
  logic [31:0]     r_mem_pc    [DEPTH];

  state_t          w_state_n;
  logic            w_request_n;
  logic [31:0]     w_address_n;
  logic [31:0]     w_fetch_pc_n;
  logic            w_push;
  logic            w_pop;
  logic [31:0]     w_flush_pc;

  assign w_flush_pc = i_flush_pc & 32'hFFFF_FFFC;
  assign w_pop      = i_pop && (r_count != '0) && !i_flush;

  // Handshake: o_request rises with o_address and both hold until the cycle
  // i_ready is sampled high; that cycle completes the read and carries i_data.
  always_comb begin
    w_state_n    = r_state;
    w_request_n  = r_request;
    w_address_n  = r_address;
    w_fetch_pc_n = r_fetch_pc;
    w_push       = 1'b0;
    case (r_state)
      ST_ISSUE: begin
        if (i_flush) begin
          w_fetch_pc_n = w_flush_pc;
        end else if (r_count < CW'(DEPTH)) begin
          w_request_n = 1'b1;
          w_address_n = r_fetch_pc;
          w_state_n   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_ready) begin
          w_request_n = 1'b0;
          w_state_n   = ST_ISSUE;
          if (i_flush) begin
            w_fetch_pc_n = w_flush_pc;
          end else begin
            w_push       = 1'b1;
            w_fetch_pc_n = r_fetch_pc + 32'd4;
          end
        end else if (i_flush) begin
          // The bus cannot abort, so the in-flight word is waited for and dropped.
          w_fetch_pc_n = w_flush_pc;
          w_state_n    = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (i_flush) begin
          w_fetch_pc_n = w_flush_pc;
        end
        if (i_ready) begin
          w_request_n = 1'b0;
          w_state_n   = ST_ISSUE;
        end
      end
      default: begin
        w_state_n   = ST_ISSUE;
        w_request_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state    <= ST_ISSUE;
      r_request  <= 1'b0;
      r_address  <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_state    <= w_state_n;
      r_request  <= w_request_n;
      r_address  <= w_address_n;
      r_fetch_pc <= w_fetch_pc_n;
      if (i_flush) begin
        r_count <= '0;
        r_head  <= '0;
        r_tail  <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + AW'(1);
        if (w_pop)  r_head <= r_head + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_mem_instr[r_tail] <= i_data;
      r_mem_pc[r_tail]    <= r_address;
    end
  end

  assign o_request     = r_request;
  assign o_rw          = 1'b0;
  assign o_address     = r_address;
  assign o_valid       = (r_count != '0);
  assign o_instruction = r_mem_instr[r_head];
  assign o_pc          = r_mem_pc[r_head];
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_cpu_prefetch.sv
// Bench for cpu_prefetch: behavioural bus memory with programmable latency and
// an expected-pc queue checked against the queue head on every pop.
module tb_cpu_prefetch;

  logic        clk;
  logic        i_reset;
  logic        o_request;
  logic        o_rw;
  logic [31:0] o_address;
  logic        i_ready;
  logic [31:0] i_data;
  logic        o_valid;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
  logic        i_pop;
  logic        i_flush;
  logic [31:0] i_flush_pc;
  logic [1:0]  o_dbg_state;

  int          checks;
  int          failures;
  int          lat;
  int          cyc;
  logic [31:0] exp_q[$];
  logic [31:0] req_log[$];
  int          pop_times[$];

  cpu_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0200)) dut (
    .i_clock(clk), .i_reset(i_reset), .o_request(o_request), .o_rw(o_rw),
    .o_address(o_address), .i_ready(i_ready), .i_data(i_data),
    .o_valid(o_valid), .o_instruction(o_instruction), .o_pc(o_pc),
    .i_pop(i_pop), .i_flush(i_flush), .i_flush_pc(i_flush_pc),
    .o_dbg_state(o_dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  // Bus memory: answers after `lat` waiting cycles, logs each new request.
  initial begin : responder
    int          wcnt;
    logic        prev_req;
    logic [31:0] prev_addr;
    i_ready = 1'b0; i_data = '0; wcnt = 0; prev_req = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (o_request) begin
        if (!prev_req) req_log.push_back(o_address);
        else begin
          checks++;
          if (o_address !== prev_addr) begin
            failures++;
            $display("FAIL addr_stable: got %h required %h", o_address, prev_addr);
          end
        end
        if (wcnt >= lat) begin
          i_ready = 1'b1; i_data = mem_word(o_address); wcnt = 0;
        end else begin
          i_ready = 1'b0; i_data = 32'hDEAD_BEEF; wcnt++;
        end
      end else begin
        i_ready = 1'b0; wcnt = 0;
      end
      prev_req = o_request;
      prev_addr = o_address;
    end
  end

  task automatic do_flush(input logic [31:0] pc);
    @(negedge clk);
    i_flush = 1'b1; i_flush_pc = pc; exp_q.delete();
    @(negedge clk);
    i_flush = 1'b0;
    req_log.delete();
  endtask

  task automatic pop_check(input int n, input int budget);
    int got;
    logic [31:0] e;
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if (o_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pop_unexpected: got pc %h required no entry", o_pc);
        end else begin
          e = exp_q.pop_front();
          if (o_pc !== e || o_instruction !== mem_word(e)) begin
            failures++;
            $display("FAIL pop_head: got pc %h instr %h required pc %h instr %h",
                     o_pc, o_instruction, e, mem_word(e));
          end
        end
        pop_times.push_back(cyc);
        i_pop = 1'b1;
        got++;
      end else begin
        i_pop = 1'b0;
      end
    end
    @(negedge clk);
    i_pop = 1'b0;
    checks++;
    if (got != n) begin
      failures++;
      $display("FAIL pop_timeout: got %0d pops required %0d", got, n);
    end
  endtask

  task automatic test_reset;
    i_reset = 1'b0; i_pop = 1'b0; i_flush = 1'b0; i_flush_pc = '0; lat = 0;
    repeat (3) @(negedge clk);
    checks += 5;
    if (o_request !== 1'b0) begin failures++; $display("FAIL rst_request: got %b required 0", o_request); end
    if (o_rw !== 1'b0) begin failures++; $display("FAIL rst_rw: got %b required 0", o_rw); end
    if (o_address !== 32'h200) begin failures++; $display("FAIL rst_address: got %h required 00000200", o_address); end
    if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b required 0", o_valid); end
    if (o_dbg_state !== 2'd0) begin failures++; $display("FAIL rst_state: got %0d required 0", o_dbg_state); end
  endtask

  task automatic test_fill;
    logic [31:0] want;
    @(negedge clk);
    i_reset = 1'b1; req_log.delete();
    @(negedge clk);
    checks++;
    if (o_request !== 1'b1 || o_address !== 32'h200) begin
      failures++; $display("FAIL first_request: got req %b addr %h required 1 00000200", o_request, o_address);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (req_log.size() != 4) begin
      failures++; $display("FAIL fill_count: got %0d requests required 4", req_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        want = 32'h200 + 32'(4 * i);
        checks++;
        if (req_log[i] !== want) begin failures++; $display("FAIL fill_addr%0d: got %h required %h", i, req_log[i], want); end
      end
    end
    checks += 3;
    if (o_request !== 1'b0) begin failures++; $display("FAIL full_idle: got %b required 0", o_request); end
    if (o_valid !== 1'b1) begin failures++; $display("FAIL full_valid: got %b required 1", o_valid); end
    if (o_pc !== 32'h200) begin failures++; $display("FAIL full_head_pc: got %h required 00000200", o_pc); end
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h200 + 32'(4 * i));
    pop_check(4, 40);
  endtask

  task automatic test_stream;
    do_flush(32'h400);
    pop_times.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back(32'h400 + 32'(4 * i));
    pop_check(10, 60);
    for (int i = 1; i < pop_times.size(); i++) begin
      checks++;
      if (pop_times[i] - pop_times[i-1] != 2) begin
        failures++; $display("FAIL stream_rate%0d: got gap %0d required 2", i, pop_times[i] - pop_times[i-1]);
      end
    end
  endtask

  task automatic test_flush_queued;
    do_flush(32'h2000);
    repeat (6) @(negedge clk);
    checks += 2;
    if (o_valid !== 1'b1 || o_pc !== 32'h2000) begin
      failures++; $display("FAIL q3_head: got valid %b pc %h required 1 00002000", o_valid, o_pc);
    end
    if (o_request !== 1'b0) begin failures++; $display("FAIL q3_req: got %b required 0", o_request); end
    i_flush = 1'b1; i_flush_pc = 32'h1003; exp_q.delete();
    @(negedge clk);
    i_flush = 1'b0;
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL flush_empty: got %b required 0", o_valid); end
    @(negedge clk);
    checks++;
    if (o_request !== 1'b1 || o_address !== 32'h1000) begin
      failures++; $display("FAIL flush_addr: got req %b addr %h required 1 00001000", o_request, o_address);
    end
    exp_q.push_back(32'h1000); exp_q.push_back(32'h1004);
    pop_check(2, 20);
  endtask

  task automatic test_flush_discard;
    do_flush(32'h200);
    repeat (4) @(negedge clk);
    lat = 5;
    @(negedge clk);
    checks++;
    if (o_request !== 1'b1 || o_address !== 32'h208) begin
      failures++; $display("FAIL slow_req: got req %b addr %h required 1 00000208", o_request, o_address);
    end
    i_flush = 1'b1; i_flush_pc = 32'h5000; exp_q.delete();
    @(negedge clk);
    checks++;
    if (o_request !== 1'b1 || o_dbg_state !== 2'd2) begin
      failures++; $display("FAIL discard_enter: got req %b state %0d required 1 2", o_request, o_dbg_state);
    end
    i_flush_pc = 32'h3000;
    @(negedge clk);
    i_flush = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!o_request) break;
      checks++;
      if (o_address !== 32'h208) begin failures++; $display("FAIL discard_hold: got %h required 00000208", o_address); end
    end
    checks += 2;
    if (o_request !== 1'b0) begin failures++; $display("FAIL discard_timeout: got req %b required 0", o_request); end
    if (o_valid !== 1'b0) begin failures++; $display("FAIL discard_drop: got valid %b required 0", o_valid); end
    lat = 0;
    @(negedge clk);
    checks++;
    if (o_request !== 1'b1 || o_address !== 32'h3000) begin
      failures++; $display("FAIL refetch_addr: got req %b addr %h required 1 00003000", o_request, o_address);
    end
    exp_q.push_back(32'h3000); exp_q.push_back(32'h3004);
    pop_check(2, 20);
  endtask

  task automatic test_wrap;
    do_flush(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    pop_check(3, 30);
  endtask

  task automatic test_reset_mid;
    do_flush(32'h600);
    repeat (10) @(negedge clk);
    checks++;
    if (o_request !== 1'b0 || o_valid !== 1'b1) begin
      failures++; $display("FAIL rm_full: got req %b valid %b required 0 1", o_request, o_valid);
    end
    lat = 10;
    i_pop = 1'b1;
    @(negedge clk);
    i_pop = 1'b0;
    @(negedge clk);
    checks++;
    if (o_request !== 1'b1 || o_address !== 32'h610) begin
      failures++; $display("FAIL rm_req: got req %b addr %h required 1 00000610", o_request, o_address);
    end
    i_reset = 1'b0;
    @(negedge clk);
    checks += 4;
    if (o_request !== 1'b0) begin failures++; $display("FAIL rm_request: got %b required 0", o_request); end
    if (o_valid !== 1'b0) begin failures++; $display("FAIL rm_valid: got %b required 0", o_valid); end
    if (o_address !== 32'h200 || o_rw !== 1'b0) begin
      failures++; $display("FAIL rm_address: got %h rw %b required 00000200 0", o_address, o_rw);
    end
    if (o_dbg_state !== 2'd0) begin failures++; $display("FAIL rm_state: got %0d required 0", o_dbg_state); end
    lat = 0; exp_q.delete();
    i_reset = 1'b1;
    exp_q.push_back(32'h200); exp_q.push_back(32'h204);
    pop_check(2, 20);
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_fill();
    test_stream();
    test_flush_queued();
    test_flush_discard();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
